// File: rtl/periph_bridge.sv
// periph_bridge: single-outstanding bridge from the CPU memory stage to two
// timer/counter units and the interrupt generator. A request is latched and
// decoded in IDLE, the selected peripheral is strobed in ACCESS, and the
// response is presented for one cycle in RESP.
module periph_bridge #(
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] INT_BASE = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [29:0] tc0_addr,
    output logic        tc0_we,
    output logic [31:0] tc0_din,
    input  logic [31:0] tc0_dout,
    input  logic        tc0_irq,
    output logic [29:0] tc1_addr,
    output logic        tc1_we,
    output logic [31:0] tc1_din,
    input  logic [31:0] tc1_dout,
    input  logic        tc1_irq,
    input  logic        int_irq,
    output logic        int_we,
    output logic [5:0]  hwint
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        accept;
    logic        hit_tc0, hit_tc1, hit_int, fault;
    logic        we_q;
    logic [2:0]  sel_q;      // {int, tc1, tc0}; all-zero for a faulting access
    logic        err_q;
    logic [29:0] tc0_addr_q, tc1_addr_q;
    logic [31:0] tc0_din_q, tc1_din_q;
    logic [31:0] rdata_q, rdata_d;
    logic [5:0]  hwint_q;

    assign accept = (state_q == StIdle) && cpu_req;

    // Address decode and fault detection on the incoming request.
    always_comb begin
        hit_tc0 = (cpu_addr >= TC0_BASE) && (cpu_addr <= TC0_BASE + 32'd8);
        hit_tc1 = (cpu_addr >= TC1_BASE) && (cpu_addr <= TC1_BASE + 32'd8);
        hit_int = (cpu_addr == INT_BASE);
        // Byte enables only matter for the fault check, so they are folded
        // into err_q rather than stored separately.
        fault   = (cpu_addr[1:0] != 2'b00)
                || !(hit_tc0 || hit_tc1 || hit_int)
                || (cpu_we && (cpu_byteen != 4'hF));
    end

    // Next-state logic: IDLE -> ACCESS on request, then ACCESS -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cpu_req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Latch the request attributes and decode result on the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q  <= 1'b0;
            sel_q <= 3'b000;
            err_q <= 1'b0;
        end else if (accept) begin
            we_q  <= cpu_we;
            sel_q <= fault ? 3'b000 : {hit_int, hit_tc1, hit_tc0};
            err_q <= fault;
        end
    end

    // TC address/data registers: loaded only for a clean hit, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc0_addr_q <= '0;
            tc0_din_q  <= '0;
            tc1_addr_q <= '0;
            tc1_din_q  <= '0;
        end else if (accept && !fault) begin
            if (hit_tc0) begin
                tc0_addr_q <= cpu_addr[31:2];
                tc0_din_q  <= cpu_wdata;
            end
            if (hit_tc1) begin
                tc1_addr_q <= cpu_addr[31:2];
                tc1_din_q  <= cpu_wdata;
            end
        end
    end

    // Read data captured at the end of ACCESS; INT loads and faults return 0.
    always_comb begin
        rdata_d = rdata_q;
        if (state_q == StAccess) begin
            rdata_d = 32'h0;
            if (!we_q && sel_q[0]) rdata_d = tc0_dout;
            if (!we_q && sel_q[1]) rdata_d = tc1_dout;
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata_q <= 32'h0;
        else        rdata_q <= rdata_d;
    end

    // Interrupt lines re-registered every cycle, independent of the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hwint_q <= 6'h00;
        else        hwint_q <= {3'b000, int_irq, tc1_irq, tc0_irq};
    end

    // Strobes are decoded from the state register so reset drops them at once.
    assign tc0_we    = (state_q == StAccess) && we_q && sel_q[0];
    assign tc1_we    = (state_q == StAccess) && we_q && sel_q[1];
    assign int_we    = (state_q == StAccess) && we_q && sel_q[2];
    assign tc0_addr  = tc0_addr_q;
    assign tc0_din   = tc0_din_q;
    assign tc1_addr  = tc1_addr_q;
    assign tc1_din   = tc1_din_q;
    assign cpu_ready = (state_q == StResp);
    assign cpu_err   = (state_q == StResp) && err_q;
    assign cpu_rdata = rdata_q;
    assign hwint     = hwint_q;

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: randomized bench with behavioural TC stand-ins and a
// reference model of the bridge's decode/fault/response rules.
module tb_periph_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_ready, cpu_err;
    logic [31:0] cpu_rdata;
    logic [29:0] tc0_addr, tc1_addr;
    logic        tc0_we, tc1_we, int_we;
    logic [31:0] tc0_din, tc1_din, tc0_dout, tc1_dout;
    logic        tc0_irq, tc1_irq, int_irq;
    logic [5:0]  hwint;

    int n_cmp = 0;
    int n_err = 0;

    periph_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_byteen (cpu_byteen),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .tc0_addr   (tc0_addr),
        .tc0_we     (tc0_we),
        .tc0_din    (tc0_din),
        .tc0_dout   (tc0_dout),
        .tc0_irq    (tc0_irq),
        .tc1_addr   (tc1_addr),
        .tc1_we     (tc1_we),
        .tc1_din    (tc1_din),
        .tc1_dout   (tc1_dout),
        .tc1_irq    (tc1_irq),
        .int_irq    (int_irq),
        .int_we     (int_we),
        .hwint      (hwint)
    );

    always #5 clk = ~clk;

    // Behavioural TC stand-ins: CTRL/PRESET writable, COUNT reads 0.
    logic [31:0] tc0_mem [3];
    logic [31:0] tc1_mem [3];
    logic [29:0] off0, off1;

    always_comb begin
        off0 = tc0_addr - 30'h1FC0;
        off1 = tc1_addr - 30'h1FC4;
        tc0_dout = (off0 < 30'd3) ? tc0_mem[off0[1:0]] : 32'h0;
        tc1_dout = (off1 < 30'd3) ? tc1_mem[off1[1:0]] : 32'h0;
    end

    always @(posedge clk) begin
        if (tc0_we && off0 < 30'd2) tc0_mem[off0[1:0]] <= tc0_din;
        if (tc1_we && off1 < 30'd2) tc1_mem[off1[1:0]] <= tc1_din;
    end

    // Reference storage: [unit][word] for CTRL and PRESET of each TC.
    logic [31:0] ref_mem [2][2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Random interrupt inputs, changed away from the active edge.
    initial begin
        tc0_irq = 1'b0; tc1_irq = 1'b0; int_irq = 1'b0;
        forever begin
            @(negedge clk);
            {int_irq, tc1_irq, tc0_irq} = 3'($urandom);
        end
    end

    // hwint must equal the irq inputs seen at the previous rising edge.
    initial begin
        logic [5:0] exp_hw;
        forever begin
            @(posedge clk);
            exp_hw = reset ? {3'b000, int_irq, tc1_irq, tc0_irq} : 6'h00;
            #1;
            check("hwint", 32'(hwint), 32'(exp_hw));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(cpu_ready), 32'h0);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
        check({tag, "_err"}, 32'(cpu_err), 32'h0);
        check({tag, "_tc0_addr"}, 32'(tc0_addr), 32'h0);
        check({tag, "_tc1_addr"}, 32'(tc1_addr), 32'h0);
        check({tag, "_tc0_din"}, tc0_din, 32'h0);
        check({tag, "_tc1_din"}, tc1_din, 32'h0);
        check({tag, "_we"}, 32'({tc0_we, tc1_we, int_we}), 32'h0);
        check({tag, "_hwint"}, 32'(hwint), 32'h0);
    endtask

    // One full transaction from an idle bridge, with checks at each phase.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd);
        int          unit;
        logic [31:0] base, off;
        int          word;
        logic        err;
        logic [31:0] exp_rd;
        unit = -1;
        base = 32'h0;
        if (addr >= 32'h7F00 && addr <= 32'h7F08) begin unit = 0; base = 32'h7F00; end
        if (addr >= 32'h7F10 && addr <= 32'h7F18) begin unit = 1; base = 32'h7F10; end
        if (addr == 32'h7F20) unit = 2;
        off  = addr - base;
        word = int'(off >> 2);
        err  = (addr[1:0] != 2'b00) || (unit < 0) || (we && be != 4'hF);
        exp_rd = 32'h0;
        if (!err && !we && unit < 2 && word < 2) exp_rd = ref_mem[unit][word];

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_byteen = be; cpu_wdata = wd;
        @(posedge clk); #1;
        check("tc0_we", 32'(tc0_we), 32'(!err && we && unit == 0));
        check("tc1_we", 32'(tc1_we), 32'(!err && we && unit == 1));
        check("int_we", 32'(int_we), 32'(!err && we && unit == 2));
        check("ready_early", 32'(cpu_ready), 32'h0);
        if (!err && unit == 0) begin
            check("tc0_addr", 32'(tc0_addr), 32'(addr[31:2]));
            check("tc0_din", tc0_din, wd);
        end
        if (!err && unit == 1) begin
            check("tc1_addr", 32'(tc1_addr), 32'(addr[31:2]));
            check("tc1_din", tc1_din, wd);
        end
        // Inputs are don't-care after acceptance; scramble them.
        cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom;
        cpu_byteen = 4'($urandom); cpu_wdata = $urandom;
        @(posedge clk); #1;
        check("ready", 32'(cpu_ready), 32'h1);
        check("err", 32'(cpu_err), 32'(err));
        check("rdata", cpu_rdata, exp_rd);
        check("we_resp", 32'({tc0_we, tc1_we, int_we}), 32'h0);
        if (!err && we && unit < 2 && word < 2) ref_mem[unit][word] = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check("ready_pulse", 32'(cpu_ready), 32'h0);
    endtask

    initial begin
        logic [31:0] cand [12];
        int          n_rdy, n_we;
        logic [31:0] a;
        cand = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C, 32'h7F10, 32'h7F14,
                 32'h7F18, 32'h7F1C, 32'h7F20, 32'h7F24, 32'h7F02, 32'h7EFC};
        for (int u = 0; u < 3; u++) begin tc0_mem[u] = 32'h0; tc1_mem[u] = 32'h0; end
        for (int u = 0; u < 2; u++) for (int w = 0; w < 2; w++) ref_mem[u][w] = 32'h0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_byteen = 4'h0; cpu_wdata = 32'h0;
        reset = 1'b0;
        #2;
        check_all_zero("rst");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_access(1'b1, 32'h7F00, 4'hF, 32'h0000_0009);
        do_access(1'b1, 32'h7F14, 4'hF, 32'h0000_0005);
        do_access(1'b0, 32'h7F14, 4'hF, 32'h0);
        do_access(1'b0, 32'h7F0C, 4'hF, 32'h0);
        do_access(1'b0, 32'h7F02, 4'hF, 32'h0);
        do_access(1'b1, 32'h7F00, 4'h3, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h7F00, 4'hF, 32'h0);
        do_access(1'b1, 32'h7F20, 4'hF, 32'h1);
        do_access(1'b0, 32'h7F20, 4'hF, 32'h0);

        // Request held high: one accept every three cycles.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F04; cpu_byteen = 4'hF;
        cpu_wdata = 32'h77;
        n_rdy = 0; n_we = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (cpu_ready) n_rdy++;
            if (tc0_we) n_we++;
        end
        cpu_req = 1'b0;
        ref_mem[0][1] = 32'h77;
        check("held_ready_cnt", 32'(n_rdy), 32'd4);
        check("held_we_cnt", 32'(n_we), 32'd4);
        do_access(1'b0, 32'h7F04, 4'hF, 32'h0);

        // Reset during ACCESS of a store (to COUNT, so the TC contents are unaffected).
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F18; cpu_byteen = 4'hF;
        cpu_wdata = 32'h1234_5678;
        @(posedge clk); #2;
        check("mid_tc1_we", 32'(tc1_we), 32'h1);
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk); reset = 1'b1;
        do_access(1'b1, 32'h7F10, 4'hF, 32'h0000_00A5);
        do_access(1'b0, 32'h7F10, 4'hF, 32'h0);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            a = cand[$urandom_range(0, 11)];
            do_access(1'($urandom), a, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF,
                      $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
